// File: rtl/fp_mac_pkg.sv
// Shared constants, controller state encoding and tag sizing for the FP32 MAC sequencer.
package fp_mac_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    ACCUM  = 3'd0,
    DRAIN  = 3'd1,
    REDUCE = 3'd2,
    RWAIT  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Tag travels with each issue as {reduce_flag, lane}.
  function automatic int tag_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/fp_mac_seq_ctrl_if.sv
// Operand stream, datapath issue/return, and result channels of the MAC sequencer.
// slave = controller view; master = environment (source, datapath, consumer) view.
interface fp_mac_seq_ctrl_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  localparam int TAG_W = fp_mac_pkg::tag_w(LANES);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_last;

  logic             mac_issue;
  logic [31:0]      mac_a;
  logic [31:0]      mac_b;
  logic [31:0]      mac_acc;
  logic [TAG_W-1:0] mac_tag;

  logic             res_valid;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             err_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_valid, res_data, res_tag, out_ready,
    output in_ready, mac_issue, mac_a, mac_b, mac_acc, mac_tag,
           out_valid, out_data, out_count, err_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_last, res_valid, res_data, res_tag, out_ready,
    input  in_ready, mac_issue, mac_a, mac_b, mac_acc, mac_tag,
           out_valid, out_data, out_count, err_tag
  );
endinterface

// File: rtl/fp_mac_lane_rf.sv
// Per-lane partial sums with pending bits; one result write port, bypassed issue read, reduce read.
// Zero-latency reads; the issue port reports a lane free when idle or its result returns this cycle.
module fp_mac_lane_rf #(
  parameter  int LANES = 4,
  localparam int LW    = $clog2(LANES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_res_vld,
  input  logic [LW-1:0] i_res_lane,
  input  logic [31:0]   i_res_dat,
  input  logic          i_set_en,
  input  logic [LW-1:0] i_set_lane,
  input  logic          i_clr_all,
  input  logic [LW-1:0] i_rd_lane,
  output logic [31:0]   o_rd_dat,
  output logic          o_rd_free,
  input  logic [LW-1:0] i_rd2_lane,
  output logic [31:0]   o_rd2_dat,
  output logic          o_pend_any,
  output logic          o_stray
);

  logic [31:0]      r_part [LANES];
  logic [LANES-1:0] r_pend;
  logic             w_hit_wr;
  logic             w_bypass;
  logic [LANES-1:0] w_set;
  logic [LANES-1:0] w_clr;

  // Results for lanes not in flight are dropped so they cannot corrupt a sum.
  assign w_hit_wr = i_res_vld && r_pend[i_res_lane];
  assign o_stray  = i_res_vld && !r_pend[i_res_lane];
  assign w_bypass = w_hit_wr && (i_res_lane == i_rd_lane);

  assign o_rd_dat   = w_bypass ? i_res_dat : r_part[i_rd_lane];
  assign o_rd_free  = !r_pend[i_rd_lane] || w_bypass;
  assign o_rd2_dat  = r_part[i_rd2_lane];
  assign o_pend_any = |r_pend;

  assign w_set = i_set_en ? (LANES'(1) << i_set_lane) : '0;
  assign w_clr = w_hit_wr ? (LANES'(1) << i_res_lane) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= '0;
      for (int i = 0; i < LANES; i++) r_part[i] <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (i_clr_all) begin
        for (int i = 0; i < LANES; i++) r_part[i] <= '0;
      end else if (w_hit_wr) begin
        r_part[i_res_lane] <= i_res_dat;
      end
    end
  end

endmodule

// File: rtl/fp_mac_seq_ctrl.sv
// Dot-product sequencer: one MAC issue per beat round-robin over lanes, then serial lane reduction.
// Result in DONE is held until out_ready; operands stall only while the target lane is still in flight.
module fp_mac_seq_ctrl
  import fp_mac_pkg::*;
#(
  parameter int PIPE_LAT = 4,
  parameter int LANES    = 4,
  parameter int CNT_W    = 16
) (
  input logic              CLK,
  input logic              RESETn,
  fp_mac_seq_ctrl_if.slave bus
);

  localparam int LW    = $clog2(LANES);
  localparam int TAG_W = tag_w(LANES);

  if (LANES < PIPE_LAT) begin : g_cfg_chk
    $error("fp_mac_seq_ctrl: LANES must be >= PIPE_LAT");
  end

  state_e           r_state;
  state_e           w_state_nx;
  logic [LW-1:0]    r_lane_ptr;
  logic [LW-1:0]    r_k;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_red;
  logic             r_err;

  logic             w_res_part;
  logic             w_res_red;
  logic             w_red_hit;
  logic             w_issue_acc;
  logic             w_clr_all;
  logic             w_lane_free;
  logic             w_pend_any;
  logic             w_stray;
  logic             w_k_last;
  logic             w_drain_done;
  logic [LW-1:0]    w_rd2_lane;
  logic [31:0]      w_rd_dat;
  logic [31:0]      w_rd2_dat;

  assign w_res_part   = bus.res_valid && !bus.res_tag[TAG_W-1];
  assign w_res_red    = bus.res_valid && bus.res_tag[TAG_W-1];
  assign w_red_hit    = w_res_red && (r_state == RWAIT);
  assign w_issue_acc  = (r_state == ACCUM) && bus.in_valid && w_lane_free;
  assign w_clr_all    = (r_state == DONE) && bus.out_ready;
  assign w_drain_done = (r_state == DRAIN) && !w_pend_any;
  assign w_k_last     = (r_k == LW'(LANES - 1));
  // DRAIN seeds the reduction with lane 0; REDUCE then walks lanes 1..LANES-1.
  assign w_rd2_lane   = (r_state == DRAIN) ? '0 : r_k;

  fp_mac_lane_rf #(.LANES(LANES)) u_lane_rf (
    .i_clk      (CLK),
    .i_rst_n    (RESETn),
    .i_res_vld  (w_res_part),
    .i_res_lane (bus.res_tag[LW-1:0]),
    .i_res_dat  (bus.res_data),
    .i_set_en   (w_issue_acc),
    .i_set_lane (r_lane_ptr),
    .i_clr_all  (w_clr_all),
    .i_rd_lane  (r_lane_ptr),
    .o_rd_dat   (w_rd_dat),
    .o_rd_free  (w_lane_free),
    .i_rd2_lane (w_rd2_lane),
    .o_rd2_dat  (w_rd2_dat),
    .o_pend_any (w_pend_any),
    .o_stray    (w_stray)
  );

  always_comb begin
    w_state_nx    = r_state;
    bus.in_ready  = 1'b0;
    bus.mac_issue = 1'b0;
    bus.mac_a     = FP_ZERO;
    bus.mac_b     = FP_ZERO;
    bus.mac_acc   = FP_ZERO;
    bus.mac_tag   = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = FP_ZERO;
    bus.out_count = '0;
    case (r_state)
      ACCUM: begin
        bus.in_ready = w_lane_free;
        if (w_issue_acc) begin
          bus.mac_issue = 1'b1;
          bus.mac_a     = bus.in_a;
          bus.mac_b     = bus.in_b;
          bus.mac_acc   = w_rd_dat;
          bus.mac_tag   = {1'b0, r_lane_ptr};
          if (bus.in_last) w_state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_done) w_state_nx = REDUCE;
      end
      REDUCE: begin
        // part[k]*1.0 + red reuses the MAC datapath as a plain adder.
        bus.mac_issue = 1'b1;
        bus.mac_a     = w_rd2_dat;
        bus.mac_b     = FP_ONE;
        bus.mac_acc   = r_red;
        bus.mac_tag   = {1'b1, {LW{1'b0}}};
        w_state_nx    = RWAIT;
      end
      RWAIT: begin
        if (w_red_hit) w_state_nx = w_k_last ? DONE : REDUCE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_red;
        bus.out_count = r_count;
        if (bus.out_ready) w_state_nx = ACCUM;
      end
      default: w_state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= ACCUM;
      r_lane_ptr <= '0;
      r_k        <= '0;
      r_count    <= '0;
      r_red      <= FP_ZERO;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_issue_acc) begin
        r_lane_ptr <= r_lane_ptr + LW'(1);
        r_count    <= r_count + CNT_W'(1);
      end
      if (w_drain_done) begin
        r_red <= w_rd2_dat;
        r_k   <= LW'(1);
      end
      if (w_red_hit) begin
        r_red <= bus.res_data;
        if (!w_k_last) r_k <= r_k + LW'(1);
      end
      if (w_clr_all) begin
        r_count    <= '0;
        r_lane_ptr <= '0;
      end
      // A reduce-tagged result outside RWAIT has no matching issue either.
      if (w_stray || (w_res_red && (r_state != RWAIT))) r_err <= 1'b1;
    end
  end

  assign bus.err_tag = r_err;

endmodule

// File: tb/tb_fp_mac_seq_ctrl.sv
// Bench for fp_mac_seq_ctrl: behavioural FP datapath with fixed latency, real-valued dot-product reference.
module tb_fp_mac_seq_ctrl;

  localparam int PIPE_LAT = 4;
  localparam int LANES    = 4;
  localparam int CNT_W    = 16;
  localparam int TAG_W    = $clog2(LANES) + 1;
  localparam int LAT_MAX  = PIPE_LAT + 2 + (LANES - 1) * (PIPE_LAT + 1) + 1;

  localparam logic [31:0] OPS [10] = '{
    32'h3E80_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000,
    32'h4040_0000, 32'h4080_0000, 32'hBF80_0000, 32'hC000_0000, 32'h0000_0000
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_mac_seq_ctrl_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

  fp_mac_seq_ctrl #(.PIPE_LAT(PIPE_LAT), .LANES(LANES), .CNT_W(CNT_W)) u_dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;
  int red_issues = 0;
  int acc_issues = 0;
  logic [31:0] last_data;
  logic [31:0] va[$];
  logic [31:0] vb[$];

  logic             inj_vld = 1'b0;
  logic [TAG_W-1:0] inj_tag = '0;
  logic [31:0]      inj_dat = '0;

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Datapath: a*b+acc, returned PIPE_LAT cycles after issue; reset with the controller.
  logic [PIPE_LAT-1:0] dp_v;
  logic [31:0]         dp_d [PIPE_LAT];
  logic [TAG_W-1:0]    dp_t [PIPE_LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        dp_d[i] <= '0;
        dp_t[i] <= '0;
      end
    end else begin
      dp_v[0] <= bus.mac_issue;
      dp_d[0] <= r2f(f2r(bus.mac_a) * f2r(bus.mac_b) + f2r(bus.mac_acc));
      dp_t[0] <= bus.mac_tag;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dp_v[i] <= dp_v[i-1];
        dp_d[i] <= dp_d[i-1];
        dp_t[i] <= dp_t[i-1];
      end
    end
  end

  assign bus.res_valid = dp_v[PIPE_LAT-1] | inj_vld;
  assign bus.res_data  = inj_vld ? inj_dat : dp_d[PIPE_LAT-1];
  assign bus.res_tag   = inj_vld ? inj_tag : dp_t[PIPE_LAT-1];

  always @(posedge clk) begin
    if (rst_n && bus.mac_issue) begin
      if (bus.mac_tag[TAG_W-1]) red_issues <= red_issues + 1;
      else                      acc_issues <= acc_issues + 1;
    end
  end

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    stall_cnt += guard;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic run_vec(input int gap_max, input int hold);
    real         sum;
    int          n;
    int          red0;
    int          acc0;
    int          waited;
    logic [31:0] exp_d;
    logic [31:0] first_d;
    n = va.size();
    sum = 0.0;
    stall_cnt = 0;
    red0 = red_issues;
    acc0 = acc_issues;
    for (int i = 0; i < n; i++) begin
      sum += f2r(va[i]) * f2r(vb[i]);
      send_beat(va[i], vb[i], (i == n - 1));
      if (gap_max > 0 && i < n - 1) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    end
    exp_d = r2f(sum);
    waited = 0;
    while (!bus.out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("out_valid_rise", 32'(bus.out_valid), 32'd1);
    check_eq("latency_bound", 32'(1 + waited <= LAT_MAX), 32'd1);
    check_eq("out_data", bus.out_data, exp_d);
    check_eq("out_count", 32'(bus.out_count), 32'(n));
    first_d = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold_data", bus.out_data, first_d);
    end
    check_eq("reduce_issues", 32'(red_issues - red0), 32'(LANES - 1));
    check_eq("accum_issues", 32'(acc_issues - acc0), 32'(n));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("out_valid_fall", 32'(bus.out_valid), 32'd0);
    last_data = first_d;
    va.delete();
    vb.delete();
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      va.push_back(OPS[$urandom_range(9, 0)]);
      vb.push_back(OPS[$urandom_range(9, 0)]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", bus.out_data, 32'd0);
    check_eq("rst_out_count", 32'(bus.out_count), 32'd0);
    check_eq("rst_err_tag", 32'(bus.err_tag), 32'd0);
    check_eq("rst_mac_issue", 32'(bus.mac_issue), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", 32'(bus.in_ready), 32'd1);

    va.push_back(32'h3F80_0000); vb.push_back(32'h4000_0000);
    run_vec(0, 0);
    check_eq("single_beat", last_data, 32'h4000_0000);

    repeat (8) begin va.push_back(32'h3F80_0000); vb.push_back(32'h3F80_0000); end
    run_vec(0, 0);
    check_eq("b2b8_stalls", 32'(stall_cnt), 32'd0);
    check_eq("b2b8_sum", last_data, 32'h4100_0000);

    repeat (16) begin va.push_back(32'h3F00_0000); vb.push_back(32'h4080_0000); end
    run_vec(0, 0);
    check_eq("bypass16_stalls", 32'(stall_cnt), 32'd0);
    check_eq("bypass16_sum", last_data, 32'h4200_0000);

    fill_random(5);
    run_vec(0, 10);
    fill_random(6);
    run_vec(1, 0);

    @(negedge clk);
    inj_vld = 1'b1;
    inj_tag = TAG_W'(2);
    inj_dat = 32'h7F00_0000;
    @(negedge clk);
    inj_vld = 1'b0;
    check_eq("err_set", 32'(bus.err_tag), 32'd1);
    fill_random(7);
    run_vec(0, 0);
    check_eq("err_sticky", 32'(bus.err_tag), 32'd1);

    for (int v = 0; v < 5; v++) begin
      fill_random($urandom_range(20, 1));
      run_vec(2, $urandom_range(3, 0));
    end

    send_beat(32'h4000_0000, 32'h4000_0000, 1'b0);
    send_beat(32'h3F80_0000, 32'h4040_0000, 1'b0);
    send_beat(32'h3F00_0000, 32'h3F80_0000, 1'b1);
    g = 0;
    while (!(bus.mac_issue && bus.mac_tag[TAG_W-1]) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("reach_reduce", 32'(g < 100), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_mac_issue", 32'(bus.mac_issue), 32'd0);
    check_eq("mid_rst_out_data", bus.out_data, 32'd0);
    check_eq("mid_rst_out_count", 32'(bus.out_count), 32'd0);
    check_eq("mid_rst_err_tag", 32'(bus.err_tag), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    va.push_back(32'h4040_0000); vb.push_back(32'h3F80_0000);
    va.push_back(32'h3F80_0000); vb.push_back(32'h3F80_0000);
    run_vec(0, 0);
    check_eq("post_rst_sum", last_data, 32'h4080_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
